// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the SimpleRisc instruction prefetch queue.
package fetch_queue_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] PC_INC = 32'd4;
  localparam logic [INSTR_W-1:0] SR_NOP = 32'h6800_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] ir;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Circular {PC, IR} buffer with push/pop/clear; the head entry is always visible.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  fetch_entry_t entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic do_push;
  logic do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = entries[rd_ptr];

  // Payload storage needs no reset: it is only observed while count != 0.
  always_ff @(posedge clk) begin
    if (do_push && !clear) entries[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: single-outstanding sequential fetch, FIFO buffering,
// interlock hold and branch flush/redirect in front of operand fetch.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                 DEPTH    = 4,
  parameter logic [INSTR_W-1:0] RESET_PC = 32'h0,
  parameter logic [INSTR_W-1:0] NOP_IR   = SR_NOP
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               isDataInterLock,
  input  logic               is_Branch_Taken,
  input  logic [INSTR_W-1:0] branchPC,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_PC,
  output logic [INSTR_W-1:0] out_IR
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [INSTR_W-1:0] fetch_pc;
  logic [INSTR_W-1:0] req_pc;
  logic [INSTR_W-1:0] last_pc;
  logic               pending;
  logic               discard;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  fetch_entry_t       head;
  fetch_entry_t       wdata;
  logic               issue;
  logic               resp;
  logic               push;
  logic               pop;

  // With no request outstanding, count + pending < DEPTH reduces to !full.
  assign issue = !reset && !pending && !is_Branch_Taken && !fifo_full;
  assign resp  = imem_valid && pending;
  assign push  = resp && !discard && !is_Branch_Taken;
  assign pop   = out_valid && !isDataInterLock && !is_Branch_Taken;

  assign wdata.pc = req_pc;
  assign wdata.ir = imem_data;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (is_Branch_Taken),
    .wdata (wdata),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign out_valid = (fifo_count != '0);
  assign out_PC    = out_valid ? head.pc : last_pc;
  assign out_IR    = out_valid ? head.ir : NOP_IR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      last_pc  <= RESET_PC;
      pending  <= 1'b0;
      discard  <= 1'b0;
    end else begin
      // out_PC keeps showing the last real head once the queue drains.
      if (!fifo_empty) last_pc <= head.pc;
      if (is_Branch_Taken) begin
        fetch_pc <= branchPC;
        discard  <= pending && !imem_valid;
        if (imem_valid) pending <= 1'b0;
      end else if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + PC_INC;
        pending  <= 1'b1;
      end else if (resp) begin
        pending <= 1'b0;
        discard <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a latency-programmable instruction memory.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        isDataInterLock = 1'b0;
  logic        is_Branch_Taken = 1'b0;
  logic [31:0] branchPC = 32'h0;
  logic        out_valid;
  logic [31:0] out_PC;
  logic [31:0] out_IR;

  localparam logic [31:0] NOP = 32'h6800_0000;
  localparam logic [31:0] TAG = 32'hA000_0000;

  int checks = 0;
  int errors = 0;

  // memory model state
  int          lat = 1;
  bit          mem_en = 1'b1;
  bit          new_req = 1'b0;
  int          timer = 0;
  logic [31:0] req_addr = 32'h0;
  logic        auto_valid = 1'b0;
  logic [31:0] auto_data = 32'h0;
  logic        man_valid = 1'b0;
  logic [31:0] man_data = 32'h0;

  assign imem_valid = auto_valid | man_valid;
  assign imem_data  = man_valid ? man_data : auto_data;

  fetch_queue dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .isDataInterLock(isDataInterLock), .is_Branch_Taken(is_Branch_Taken),
    .branchPC(branchPC),
    .out_valid(out_valid), .out_PC(out_PC), .out_IR(out_IR)
  );

  always #5 clk = ~clk;

  // Responds L cycles after a request with TAG + address.
  always begin
    @(negedge clk);
    if (mem_en && imem_req) begin
      new_req  = 1'b1;
      req_addr = imem_addr;
    end
    @(posedge clk);
    #1;
    auto_valid = 1'b0;
    if (!mem_en) begin
      new_req = 1'b0;
      timer   = 0;
    end else begin
      if (new_req) begin
        timer   = lat;
        new_req = 1'b0;
      end
      if (timer > 0) begin
        timer = timer - 1;
        if (timer == 0) begin
          auto_valid = 1'b1;
          auto_data  = req_addr + TAG;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    chk("no_resp_when_full", 32'(imem_valid && dut.fifo_full), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_pc;
    int pops;
    bit found;

    // ---- reset values ----
    tick(); tick();
    sample();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_PC, 32'h0);
    chk("rst_ir", out_IR, NOP);

    // ---- L=1 sequential fetch ----
    tick(); reset = 1'b0;
    sample();
    chk("t1_req0", 32'(imem_req), 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_nop0", out_IR, NOP);
    tick(); sample();
    chk("t1_req_busy", 32'(imem_req), 32'd0);
    chk("t1_valid_early", 32'(out_valid), 32'd0);
    chk("t1_nop1", out_IR, NOP);
    tick(); sample();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_pc", out_PC, 32'h0);
    chk("t1_ir", out_IR, TAG);
    chk("t1_req4", 32'(imem_req), 32'd1);
    chk("t1_addr4", imem_addr, 32'h4);
    tick(); sample();
    chk("t1_gap_valid", 32'(out_valid), 32'd0);
    chk("t1_gap_ir", out_IR, NOP);
    chk("t1_gap_pc_hold", out_PC, 32'h0);
    tick(); sample();
    chk("t1_pc4", out_PC, 32'h4);
    chk("t1_addr8", imem_addr, 32'h8);

    // ---- interlock hold, saturate at DEPTH ----
    tick(); reset = 1'b1;
    sample();
    tick(); reset = 1'b0; isDataInterLock = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sample();
      if (i >= 8) chk($sformatf("t2_req_off_%0d", i), 32'(imem_req), 32'd0);
      if (i == 11) begin
        chk("t2_head_valid", 32'(out_valid), 32'd1);
        chk("t2_head_pc", out_PC, 32'h0);
        chk("t2_head_ir", out_IR, TAG);
      end
      tick();
    end
    isDataInterLock = 1'b0;
    exp_pc = 32'h0;
    pops = 0;
    for (int i = 0; i < 20 && pops < 5; i++) begin
      sample();
      if (out_valid) begin
        chk($sformatf("t2_order_%0d", pops), out_PC, exp_pc);
        exp_pc += 32'd4;
        pops++;
      end
      if (pops < 5) tick();
    end
    chk("t2_pops_done", 32'(pops), 32'd5);

    // ---- L=3 branch with request to 0x8 outstanding ----
    tick(); reset = 1'b1; lat = 3;
    sample();
    tick(); reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      sample();
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
      else tick();
    end
    chk("t3_saw_req8", 32'(found), 32'd1);
    tick(); is_Branch_Taken = 1'b1; branchPC = 32'h100;
    sample();
    chk("t3_flush_no_req", 32'(imem_req), 32'd0);
    tick(); is_Branch_Taken = 1'b0;
    sample();
    chk("t3_flush_empty", 32'(out_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_req) found = 1'b1;
      else begin tick(); sample(); end
    end
    chk("t3_saw_redirect", 32'(found), 32'd1);
    chk("t3_redirect_addr", imem_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(); sample();
      if (out_valid) found = 1'b1;
    end
    chk("t3_saw_target", 32'(found), 32'd1);
    chk("t3_target_pc", out_PC, 32'h100);
    chk("t3_target_ir", out_IR, TAG + 32'h100);
    lat = 1;

    // ---- branch coincident with response and interlock ----
    tick(); isDataInterLock = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      sample();
      if (imem_req) found = 1'b1;
      else tick();
    end
    chk("t4_saw_req", 32'(found), 32'd1);
    tick(); is_Branch_Taken = 1'b1; branchPC = 32'h200;
    sample();
    chk("t4_resp_present", 32'(imem_valid), 32'd1);
    chk("t4_flush_no_req", 32'(imem_req), 32'd0);
    tick(); is_Branch_Taken = 1'b0; isDataInterLock = 1'b0;
    sample();
    chk("t4_empty", 32'(out_valid), 32'd0);
    chk("t4_req_next", 32'(imem_req), 32'd1);
    chk("t4_addr_next", imem_addr, 32'h200);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(); sample();
      if (out_valid) found = 1'b1;
    end
    chk("t4_saw_target", 32'(found), 32'd1);
    chk("t4_target_pc", out_PC, 32'h200);

    // ---- random interlock and latency, pointer wrap ----
    exp_pc = 32'h204;
    pops = 0;
    for (int i = 0; i < 400 && pops < 16; i++) begin
      tick();
      isDataInterLock = 1'($urandom_range(0, 1));
      sample();
      lat = int'($urandom_range(1, 3));
      if (out_valid && !isDataInterLock) begin
        chk($sformatf("t5_pc_%0d", pops), out_PC, exp_pc);
        chk($sformatf("t5_ir_%0d", pops), out_IR, TAG + exp_pc);
        exp_pc += 32'd4;
        pops++;
      end
    end
    chk("t5_pops_done", 32'(pops), 32'd16);
    lat = 3;

    // ---- reset mid-operation, half full, request pending ----
    tick(); is_Branch_Taken = 1'b1; branchPC = 32'h400; isDataInterLock = 1'b1;
    sample();
    tick(); is_Branch_Taken = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      sample();
      if (imem_req && imem_addr == 32'h408) found = 1'b1;
      else tick();
    end
    chk("t6_saw_req408", 32'(found), 32'd1);
    chk("t6_head_pc", out_PC, 32'h400);
    tick(); reset = 1'b1; mem_en = 1'b0;
    sample();
    chk("t6_rst_req", 32'(imem_req), 32'd0);
    chk("t6_rst_addr", imem_addr, 32'h0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_pc", out_PC, 32'h0);
    chk("t6_rst_ir", out_IR, NOP);
    tick(); reset = 1'b0; isDataInterLock = 1'b0; man_valid = 1'b1; man_data = 32'hDEAD_BEEF;
    sample();
    chk("t6_restart_req", 32'(imem_req), 32'd1);
    chk("t6_restart_addr", imem_addr, 32'h0);
    tick(); man_valid = 1'b0;
    sample();
    chk("t6_stray_ignored", 32'(out_valid), 32'd0);
    chk("t6_pending", 32'(imem_req), 32'd0);
    tick(); man_valid = 1'b1; man_data = 32'h1234_5678;
    sample();
    tick(); man_valid = 1'b0;
    sample();
    chk("t6_first_valid", 32'(out_valid), 32'd1);
    chk("t6_first_pc", out_PC, 32'h0);
    chk("t6_first_ir", out_IR, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
